// File: rtl/regfile_writeback.sv
// ============================================================================
// Module   : regfile_writeback
// Purpose  : Register-file write-port arbiter merging ALU results and load
//            returns, with a load-return queue and a pending-load scoreboard.
//            Optional macro WB_FAIR_EN bounds queue starvation under ALU load.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile_writeback #(
    parameter  int WIDTH    = 32,
    parameter  int DEPTH    = 32,
    parameter  int LQ_DEPTH = 4,
    localparam int AW       = $clog2(DEPTH),
    localparam int CW       = $clog2(LQ_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alu_valid,
    output logic             alu_ready,
    input  logic [AW-1:0]    alu_rd,
    input  logic [WIDTH-1:0] alu_data,
    input  logic             ld_issue,
    input  logic [AW-1:0]    ld_issue_rd,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [AW-1:0]    ld_rd,
    input  logic [WIDTH-1:0] ld_data,
    output logic             wr_en,
    output logic [AW-1:0]    regW,
    output logic [WIDTH-1:0] portW,
    output logic [DEPTH-1:0] busy,
    output logic [CW-1:0]    lq_count
);

    localparam int          PW     = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
    localparam logic [CW-1:0] c_full = CW'(LQ_DEPTH);

    logic             r_wr_en;
    logic [AW-1:0]    r_regW;
    logic [WIDTH-1:0] r_portW;
    logic [DEPTH-1:0] r_busy;
    logic [CW-1:0]    r_count;
    logic [PW-1:0]    r_wp;
    logic [PW-1:0]    r_rp;
    logic [AW-1:0]    r_q_rd   [LQ_DEPTH];
    logic [WIDTH-1:0] r_q_data [LQ_DEPTH];

    logic             w_alu_sel;
    logic             w_q_nonempty;
    logic             w_ld_acc;
    logic             w_pop;
    logic             w_byp;
    logic             w_push;
    logic             w_sel_valid;
    logic             w_sel_load;
    logic             w_we;
    logic [AW-1:0]    w_sel_rd;
    logic [WIDTH-1:0] w_sel_data;
    logic [DEPTH-1:0] w_set;
    logic [DEPTH-1:0] w_clr;

    // ld_ready looks only at the pre-pop count, so a full queue never pushes
    assign ld_ready = !rst && (r_count < c_full);

`ifdef WB_FAIR_EN
    logic [1:0] r_starve;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve <= 2'd0;
        end else if (w_pop) begin
            r_starve <= 2'd0;
        end else if (w_alu_sel && w_q_nonempty) begin
            r_starve <= r_starve + 2'd1;
        end
    end

    assign alu_ready = !rst && (r_starve != 2'd3);
`else
    assign alu_ready = !rst;
`endif

    always_comb begin
        w_alu_sel    = alu_valid && alu_ready;
        w_q_nonempty = (r_count != '0);
        w_ld_acc     = ld_valid && ld_ready;
        w_pop        = !w_alu_sel && w_q_nonempty;
        w_byp        = !w_alu_sel && !w_q_nonempty && w_ld_acc;
        w_push       = w_ld_acc && !w_byp;
        w_sel_valid  = w_alu_sel || w_pop || w_byp;
        w_sel_load   = w_pop || w_byp;

        w_sel_rd   = alu_rd;
        w_sel_data = alu_data;
        if (w_pop) begin
            w_sel_rd   = r_q_rd[r_rp];
            w_sel_data = r_q_data[r_rp];
        end else if (w_byp) begin
            w_sel_rd   = ld_rd;
            w_sel_data = ld_data;
        end

        // x0 results are consumed silently
        w_we = w_sel_valid && (w_sel_rd != '0);

        w_set = '0;
        w_clr = '0;
        if (ld_issue && (ld_issue_rd != '0)) begin
            w_set[ld_issue_rd] = 1'b1;
        end
        if (w_sel_load && w_we) begin
            w_clr[w_sel_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_en <= 1'b0;
            r_regW  <= '0;
            r_portW <= '0;
            r_busy  <= '0;
            r_count <= '0;
            r_wp    <= '0;
            r_rp    <= '0;
        end else begin
            r_wr_en <= w_we;
            if (w_we) begin
                r_regW  <= w_sel_rd;
                r_portW <= w_sel_data;
            end
            // a same-edge issue re-marks the register after its old load lands
            r_busy <= (r_busy & ~w_clr) | w_set;
            if (w_push) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_pop) begin
                r_rp <= r_rp + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_rd[r_wp]   <= ld_rd;
            r_q_data[r_wp] <= ld_data;
        end
    end

    assign wr_en    = r_wr_en;
    assign regW     = r_regW;
    assign portW    = r_portW;
    assign busy     = r_busy;
    assign lq_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_regfile_writeback.sv
// ============================================================================
// Module   : tb_regfile_writeback
// Purpose  : Directed self-checking bench for regfile_writeback.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_regfile_writeback;

    localparam int WIDTH    = 32;
    localparam int DEPTH    = 32;
    localparam int LQ_DEPTH = 4;
    localparam int AW       = 5;
    localparam int CW       = 3;

    logic             clk;
    logic             rst;
    logic             alu_valid;
    logic             alu_ready;
    logic [AW-1:0]    alu_rd;
    logic [WIDTH-1:0] alu_data;
    logic             ld_issue;
    logic [AW-1:0]    ld_issue_rd;
    logic             ld_valid;
    logic             ld_ready;
    logic [AW-1:0]    ld_rd;
    logic [WIDTH-1:0] ld_data;
    logic             wr_en;
    logic [AW-1:0]    regW;
    logic [WIDTH-1:0] portW;
    logic [DEPTH-1:0] busy;
    logic [CW-1:0]    lq_count;

    int n_pass;
    int n_total;

    regfile_writeback #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .LQ_DEPTH (LQ_DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .ld_issue    (ld_issue),
        .ld_issue_rd (ld_issue_rd),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_rd       (ld_rd),
        .ld_data     (ld_data),
        .wr_en       (wr_en),
        .regW        (regW),
        .portW       (portW),
        .busy        (busy),
        .lq_count    (lq_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic idle_inputs();
        alu_valid   = 1'b0;
        alu_rd      = '0;
        alu_data    = '0;
        ld_issue    = 1'b0;
        ld_issue_rd = '0;
        ld_valid    = 1'b0;
        ld_rd       = '0;
        ld_data     = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        n_total++;
        if ({wr_en, regW, portW} !== 38'd0) $display("FAIL reset_port: got %0h expected 0", {wr_en, regW, portW});
        else n_pass++;
        n_total++;
        if (busy !== 32'd0 || lq_count !== 3'd0) $display("FAIL reset_state: got busy=%0h cnt=%0d expected 0/0", busy, lq_count);
        else n_pass++;
        n_total++;
        if (ld_ready !== 1'b0 || alu_ready !== 1'b0) $display("FAIL reset_ready: got ld=%0b alu=%0b expected 0/0", ld_ready, alu_ready);
        else n_pass++;
        rst = 1'b0;
        #1;
        n_total++;
        if (ld_ready !== 1'b1 || alu_ready !== 1'b1) $display("FAIL post_reset_ready: got ld=%0b alu=%0b expected 1/1", ld_ready, alu_ready);
        else n_pass++;
    endtask

    task automatic test_alu();
        @(negedge clk);
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        @(negedge clk);
        alu_valid = 1'b0;
        n_total++;
        if ({wr_en, regW, portW} !== {1'b1, 5'd5, 32'hDEADBEEF}) $display("FAIL alu_write: got %0b/%0d/%0h expected 1/5/deadbeef", wr_en, regW, portW);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (wr_en !== 1'b0 || regW !== 5'd5) $display("FAIL alu_one_pulse: got wr_en=%0b regW=%0d expected 0/5", wr_en, regW);
        else n_pass++;
    endtask

    task automatic test_bypass();
        @(negedge clk);
        ld_issue = 1'b1; ld_issue_rd = 5'd7;
        @(negedge clk);
        ld_issue = 1'b0;
        n_total++;
        if (busy[7] !== 1'b1) $display("FAIL busy_set: got %0b expected 1", busy[7]);
        else n_pass++;
        repeat (2) @(negedge clk);
        ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h1234;
        n_total++;
        if (busy !== 32'h80) $display("FAIL busy_hold: got %0h expected 80", busy);
        else n_pass++;
        @(negedge clk);
        ld_valid = 1'b0;
        n_total++;
        if ({wr_en, regW, portW} !== {1'b1, 5'd7, 32'h1234}) $display("FAIL bypass_write: got %0b/%0d/%0h expected 1/7/1234", wr_en, regW, portW);
        else n_pass++;
        n_total++;
        if (busy !== 32'd0 || lq_count !== 3'd0) $display("FAIL bypass_clear: got busy=%0h cnt=%0d expected 0/0", busy, lq_count);
        else n_pass++;
    endtask

    task automatic test_queue_order();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            alu_valid = 1'b1; alu_rd = 5'(10 + i); alu_data = 32'hA0 + i;
            ld_valid  = (i < 4); ld_rd = 5'(i + 1); ld_data = 32'd100 + i;
            #1;
            n_total++;
            if (ld_ready !== (i < 4)) $display("FAIL q_ld_ready[%0d]: got %0b expected %0b", i, ld_ready, (i < 4));
            else n_pass++;
            if (i > 0) begin
                n_total++;
                if ({wr_en, regW} !== {1'b1, 5'(9 + i)}) $display("FAIL q_alu_write[%0d]: got %0b/%0d expected 1/%0d", i, wr_en, regW, 9 + i);
                else n_pass++;
            end
        end
        @(negedge clk);
        alu_valid = 1'b0; ld_valid = 1'b0;
        n_total++;
        if (lq_count !== 3'd4 || regW !== 5'd15) $display("FAIL q_full: got cnt=%0d regW=%0d expected 4/15", lq_count, regW);
        else n_pass++;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            n_total++;
            if ({wr_en, regW, portW, lq_count} !== {1'b1, 5'(j + 1), 32'd100 + 32'(j), 3'(3 - j)})
                $display("FAIL q_drain[%0d]: got %0b/%0d/%0d/cnt%0d expected 1/%0d/%0d/cnt%0d", j, wr_en, regW, portW, lq_count, j + 1, 100 + j, 3 - j);
            else n_pass++;
        end
        @(negedge clk);
        n_total++;
        if (wr_en !== 1'b0) $display("FAIL q_drained: got wr_en=%0b expected 0", wr_en);
        else n_pass++;
    endtask

    task automatic test_x0();
        @(negedge clk);
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFF;
        ld_valid  = 1'b1; ld_rd  = 5'd0; ld_data  = 32'h55;
        ld_issue  = 1'b1; ld_issue_rd = 5'd0;
        #1;
        n_total++;
        if (alu_ready !== 1'b1 || ld_ready !== 1'b1) $display("FAIL x0_handshake: got alu=%0b ld=%0b expected 1/1", alu_ready, ld_ready);
        else n_pass++;
        @(negedge clk);
        idle_inputs();
        n_total++;
        if (wr_en !== 1'b0 || lq_count !== 3'd1 || busy !== 32'd0) $display("FAIL x0_alu: got wr_en=%0b cnt=%0d busy=%0h expected 0/1/0", wr_en, lq_count, busy);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (wr_en !== 1'b0 || lq_count !== 3'd0) $display("FAIL x0_load: got wr_en=%0b cnt=%0d expected 0/0", wr_en, lq_count);
        else n_pass++;
    endtask

    task automatic test_same_edge();
        @(negedge clk);
        ld_issue = 1'b1; ld_issue_rd = 5'd9;
        @(negedge clk);
        ld_issue = 1'b0;
        @(negedge clk);
        ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h99;
        ld_issue = 1'b1; ld_issue_rd = 5'd9;
        @(negedge clk);
        ld_issue = 1'b0; ld_data = 32'h77;
        n_total++;
        if ({wr_en, regW, portW, busy[9]} !== {1'b1, 5'd9, 32'h99, 1'b1}) $display("FAIL same_edge_set: got %0b/%0d/%0h/busy%0b expected 1/9/99/busy1", wr_en, regW, portW, busy[9]);
        else n_pass++;
        @(negedge clk);
        ld_valid = 1'b0;
        n_total++;
        if (busy[9] !== 1'b0 || portW !== 32'h77) $display("FAIL same_edge_clear: got busy%0b %0h expected busy0 77", busy[9], portW);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        ld_issue  = 1'b1; ld_issue_rd = 5'd3;
        alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'd1;
        ld_valid  = 1'b1; ld_rd  = 5'd3;  ld_data  = 32'd2;
        @(negedge clk);
        ld_issue = 1'b0; alu_rd = 5'd13; ld_rd = 5'd4;
        rst = 1'b1;
        #1;
        n_total++;
        if (alu_ready !== 1'b0 || ld_ready !== 1'b0 || lq_count !== 3'd1 || busy[3] !== 1'b1)
            $display("FAIL mid_rst_pre: got alu=%0b ld=%0b cnt=%0d busy3=%0b expected 0/0/1/1", alu_ready, ld_ready, lq_count, busy[3]);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        n_total++;
        if ({wr_en, regW, portW, busy, lq_count} !== 73'd0) $display("FAIL mid_rst_clear: got %0b/%0d/%0h/%0h/%0d expected all 0", wr_en, regW, portW, busy, lq_count);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (wr_en !== 1'b0 || lq_count !== 3'd0) $display("FAIL mid_rst_discard: got wr_en=%0b cnt=%0d expected 0/0", wr_en, lq_count);
        else n_pass++;
    endtask

`ifdef WB_FAIR_EN
    task automatic test_fair();
        int          tag;
        logic        exp_drop;
        logic [37:0] exp_prev;
        @(negedge clk);
        alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'd0;
        ld_valid  = 1'b1; ld_rd  = 5'd1;  ld_data  = 32'd11;
        @(negedge clk);
        alu_data = 32'd1; ld_rd = 5'd2; ld_data = 32'd22;
        tag      = 2;
        exp_prev = {1'b1, 5'd20, 32'd1};
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            ld_valid = 1'b0;
            alu_data = 32'(tag);
            #1;
            exp_drop = (k == 2) || (k == 6);
            n_total++;
            if (alu_ready !== !exp_drop) $display("FAIL fair_ready[%0d]: got %0b expected %0b", k, alu_ready, !exp_drop);
            else n_pass++;
            n_total++;
            if ({wr_en, regW, portW} !== exp_prev) $display("FAIL fair_write[%0d]: got %0h expected %0h", k, {wr_en, regW, portW}, exp_prev);
            else n_pass++;
            if (exp_drop) begin
                exp_prev = (k == 2) ? {1'b1, 5'd1, 32'd11} : {1'b1, 5'd2, 32'd22};
            end else begin
                exp_prev = {1'b1, 5'd20, 32'(tag)};
                tag++;
            end
        end
        @(negedge clk);
        n_total++;
        if ({wr_en, regW, portW} !== exp_prev || lq_count !== 3'd0) $display("FAIL fair_last: got %0h cnt=%0d expected %0h cnt=0", {wr_en, regW, portW}, lq_count, exp_prev);
        else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        n_total++;
        if ({wr_en, regW, portW, busy, lq_count} !== 73'd0) $display("FAIL fair_rst: got %0b/%0d/%0h expected all 0", wr_en, regW, portW);
        else n_pass++;
    endtask
`endif

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_alu();
        test_bypass();
        test_queue_order();
        test_x0();
        test_same_edge();
        test_reset_mid();
`ifdef WB_FAIR_EN
        test_fair();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Write-side front end for the 32-bit integer register file.
- Merges single-cycle ALU results and multi-cycle load returns onto the register file's single write port (wr_en/regW/portW).
- Keeps a scoreboard of registers with outstanding loads so decode can stall on RAW/WAW hazards.
- Sits between execute/memory stages and the register file.

Parameters:
- WIDTH, 32, data width of results and portW.
- DEPTH, 32, number of architectural registers; AW = $clog2(DEPTH) = 5.
- LQ_DEPTH, 4, entries in the load-return queue; power of two, minimum 2.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- alu_valid  in  1  ALU result present this cycle.
- alu_ready  out  1  ALU result will be taken this cycle.
- alu_rd  in  AW  ALU destination register.
- alu_data  in  WIDTH  ALU result.
- ld_issue  in  1  load issued; mark ld_issue_rd pending.
- ld_issue_rd  in  AW  destination of the issued load.
- ld_valid  in  1  load data returning.
- ld_ready  out  1  load return accepted when ld_valid && ld_ready.
- ld_rd  in  AW  load destination register.
- ld_data  in  WIDTH  load data.
- wr_en  out  1  register file write enable.
- regW  out  AW  register file write address.
- portW  out  WIDTH  register file write data.
- busy  out  DEPTH  scoreboard; bit r set means a load to r is outstanding.
- lq_count  out  $clog2(LQ_DEPTH+1)  occupied queue entries.

Behaviour:
- Reset: synchronous, active-high, single clock clk.
  - While rst is sampled high: wr_en=0, regW=0, portW=0, busy=0, queue emptied, lq_count=0.
  - While rst is high: ld_ready=0 and alu_ready=0.
  - Reset mid-operation discards queued loads and pending scoreboard bits.
- Write port:
  - wr_en/regW/portW are registered. A result selected in cycle N appears on the port in cycle N+1 for exactly one cycle.
  - wr_en=0 when nothing is selected. regW/portW hold their previous values.
- Selection each cycle, in priority order:
  1. ALU, if alu_valid && alu_ready.
  2. Else the queue head, if the queue is non-empty (pop).
  3. Else a bypassed load, if ld_valid and the queue is empty. It is written directly and does not occupy an entry.
- Queue accept: a load accepted and not selected in the same cycle is pushed.
- ld_ready = !rst && (lq_count < LQ_DEPTH). Combinational from the count.
  - A pop and a push in the same cycle when full is not permitted. ld_ready is computed from the pre-pop count.
- alu_ready = !rst without WB_FAIR_EN (see Optional Feature).
- Queue is FIFO. Pointers wrap modulo LQ_DEPTH. lq_count updates +1 on push only, -1 on pop only, unchanged on both.
- Register x0:
  - Any selected result with rd==0 is consumed but produces wr_en=0.
  - busy[0] is never set.
- Scoreboard:
  - ld_issue with ld_issue_rd!=0 sets busy[rd] at the next edge.
  - A load result whose write is emitted clears busy[rd] at the same edge wr_en rises.
  - Set and clear of the same bit at the same edge: set wins.
  - ld_issue to an already-busy register is a protocol error. The bit stays set and clears on the first matching return.
  - ALU writes never touch busy. Decode must stall ALU ops whose rd is busy.
- Ordering: loads are written in acceptance order. ALU results are never queued.

Optional Feature:
- Macro: WB_FAIR_EN.
- Defined:
  - A 2-bit starvation counter increments each cycle the queue is non-empty and the ALU wins selection. It resets to 0 on any pop and on rst.
  - When the counter reaches 3, alu_ready is driven 0 for one cycle and the queue head is popped.
  - Upstream ALU must hold alu_valid/alu_rd/alu_data while alu_ready=0.
- Undefined: alu_ready = !rst. Continuous ALU traffic can starve the queue indefinitely, and ld_ready stays 0 while full.

Test Plan:
- Reset, then alu_valid=1, alu_rd=5, alu_data=32'hDEADBEEF for one cycle -> next cycle wr_en=1, regW=5, portW=32'hDEADBEEF; following cycle wr_en=0.
- ld_issue rd=7; three cycles later ld_valid, ld_rd=7, ld_data=32'h1234, no ALU traffic -> busy[7]=1 from the cycle after issue; bypass write of 32'h1234 to 7 next cycle; busy[7]=0 at the same edge; lq_count stays 0.
- alu_valid held 6 cycles while loads rd=1..4 return back-to-back -> lq_count reaches 4 and ld_ready=0. After ALU stops, writes to 1,2,3,4 occur in order on consecutive cycles and lq_count returns to 0.
- alu_rd=0 and a load with ld_rd=0 -> no wr_en pulse, busy unchanged, handshakes still complete.
- Same-edge ld_issue rd=9 and emitted load write to 9 -> busy[9]=1 afterwards.
- With WB_FAIR_EN: queue holds 2 entries, alu_valid held continuously -> alu_ready drops for 1 cycle every 4th cycle, each drop pops one load, and no ALU result is lost or duplicated. Assert rst mid-sequence -> all outputs 0 next cycle.
